// File: rtl/operand_fetch.sv
// operand_fetch: decodes one MIPS instruction at a time. It waits in CHECK
// until the source registers it needs have no writer still in flight. It then
// reads the register file, forwarding writeback data where needed, and holds
// the resulting operand bundle until the consumer accepts it.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   in_valid/in_ready       upstream instruction handshake
//   in_instr                32-bit MIPS instruction word
//   rf_raddr1/rf_raddr2     register-file read addresses (rs, rt)
//   rf_rdata1/rf_rdata2     register-file read data, one cycle after address
//   wb_we/wb_addr/wb_data   writeback port (same signals that write the RF)
//   out_valid/out_ready     downstream operand-bundle handshake
//   out_opcode/funct/shamt  decoded instruction fields
//   out_rs_val/out_rt_val   resolved source operands
//   out_imm                 sign- or zero-extended immediate
//   out_dest                destination register, 0 = none
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | ready for a new instruction
// CHECK | instruction captured, waiting for its sources to be non-busy
// READ  | RF data arriving, operands resolved and latched
// HOLD  | bundle presented, waiting for out_ready

module operand_fetch (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rf_rdata1,
  input  logic [31:0] rf_rdata2,
  input  logic        wb_we,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_opcode,
  output logic [5:0]  out_funct,
  output logic [4:0]  out_shamt,
  output logic [31:0] out_rs_val,
  output logic [31:0] out_rt_val,
  output logic [31:0] out_imm,
  output logic [4:0]  out_dest
);

  typedef enum logic [1:0] {IDLE, CHECK, READ, HOLD} state_e;

  state_e      state_q;
  logic [31:0] instr_q;
  logic [31:0] busy_q;
  logic [31:0] busy_d;
  logic        byp_rs_q, byp_rt_q;
  logic [31:0] byp_rs_val_q, byp_rt_val_q;

  logic        out_valid_q;
  logic [5:0]  out_opcode_q, out_funct_q;
  logic [4:0]  out_shamt_q, out_dest_q;
  logic [31:0] out_rs_val_q, out_rt_val_q, out_imm_q;

  // Decoded view of the captured instruction
  logic [5:0]  opcode, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic        uses_rs, uses_rt, zext;
  logic [4:0]  dest;
  logic [31:0] imm_ext;

  assign opcode = instr_q[31:26];
  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign rd     = instr_q[15:11];
  assign shamt  = instr_q[10:6];
  assign funct  = instr_q[5:0];
  assign imm16  = instr_q[15:0];

  always_comb begin
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    zext    = 1'b0;
    dest    = 5'd0;
    case (opcode)
      6'h00: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
        dest    = rd;
      end
      6'h23: begin
        uses_rs = 1'b1;
        dest    = rt;
      end
      6'h2B, 6'h04, 6'h05: begin
        uses_rs = 1'b1;
        uses_rt = 1'b1;
      end
      6'h08, 6'h0A: begin
        uses_rs = 1'b1;
        dest    = rt;
      end
      6'h0C, 6'h0D: begin
        uses_rs = 1'b1;
        dest    = rt;
        zext    = 1'b1;
      end
      default: ;
    endcase
    imm_ext = zext ? {16'h0000, imm16} : {{16{imm16[15]}}, imm16};
  end

  // Hazard check looks only at the registered scoreboard, so a writeback
  // clearing a busy bit releases the stall one cycle later.
  logic stall;
  assign stall = (uses_rs && busy_q[rs]) || (uses_rt && busy_q[rt]);

  // Writeback hits on a used, nonzero source in the current cycle
  logic wb_hit_rs, wb_hit_rt;
  assign wb_hit_rs = wb_we && uses_rs && (rs != 5'd0) && (wb_addr == rs);
  assign wb_hit_rt = wb_we && uses_rt && (rt != 5'd0) && (wb_addr == rt);

  // Operand priority: live writeback, then writeback seen on the
  // CHECK->READ cycle (which the RF read missed), then RF data. Register 0
  // and sources the instruction does not use resolve to 0.
  logic [31:0] rs_val, rt_val;
  always_comb begin
    rs_val = 32'h0;
    rt_val = 32'h0;
    if (uses_rs && rs != 5'd0) begin
      if (wb_hit_rs)     rs_val = wb_data;
      else if (byp_rs_q) rs_val = byp_rs_val_q;
      else               rs_val = rf_rdata1;
    end
    if (uses_rt && rt != 5'd0) begin
      if (wb_hit_rt)     rt_val = wb_data;
      else if (byp_rt_q) rt_val = byp_rt_val_q;
      else               rt_val = rf_rdata2;
    end
  end

  // Scoreboard: a handshake marks the destination busy, a writeback clears;
  // the set is applied last so it wins on a collision.
  always_comb begin
    busy_d = busy_q;
    if (wb_we && wb_addr != 5'd0)
      busy_d[wb_addr] = 1'b0;
    if (out_valid_q && out_ready && out_dest_q != 5'd0)
      busy_d[out_dest_q] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      instr_q      <= 32'h0;
      busy_q       <= 32'h0;
      byp_rs_q     <= 1'b0;
      byp_rt_q     <= 1'b0;
      byp_rs_val_q <= 32'h0;
      byp_rt_val_q <= 32'h0;
      out_valid_q  <= 1'b0;
      out_opcode_q <= 6'h0;
      out_funct_q  <= 6'h0;
      out_shamt_q  <= 5'h0;
      out_dest_q   <= 5'h0;
      out_rs_val_q <= 32'h0;
      out_rt_val_q <= 32'h0;
      out_imm_q    <= 32'h0;
    end else begin
      busy_q <= busy_d;
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            instr_q <= in_instr;
            state_q <= CHECK;
          end
        end
        CHECK: begin
          if (!stall) begin
            byp_rs_q     <= wb_hit_rs;
            byp_rt_q     <= wb_hit_rt;
            byp_rs_val_q <= wb_data;
            byp_rt_val_q <= wb_data;
            state_q      <= READ;
          end
        end
        READ: begin
          out_opcode_q <= opcode;
          out_funct_q  <= funct;
          out_shamt_q  <= shamt;
          out_dest_q   <= dest;
          out_imm_q    <= imm_ext;
          out_rs_val_q <= rs_val;
          out_rt_val_q <= rt_val;
          out_valid_q  <= 1'b1;
          state_q      <= HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE) && !reset;
  assign rf_raddr1  = (state_q == IDLE) ? in_instr[25:21] : rs;
  assign rf_raddr2  = (state_q == IDLE) ? in_instr[20:16] : rt;

  assign out_valid  = out_valid_q;
  assign out_opcode = out_opcode_q;
  assign out_funct  = out_funct_q;
  assign out_shamt  = out_shamt_q;
  assign out_dest   = out_dest_q;
  assign out_rs_val = out_rs_val_q;
  assign out_rt_val = out_rt_val_q;
  assign out_imm    = out_imm_q;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_shamt, out_dest;
  logic [31:0] out_rs_val, out_rt_val, out_imm;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_funct(out_funct), .out_shamt(out_shamt),
    .out_rs_val(out_rs_val), .out_rt_val(out_rt_val),
    .out_imm(out_imm), .out_dest(out_dest)
  );

  // Register-file model: synchronous read, written by the writeback port.
  logic [31:0] rf [32];
  logic [31:0] rd1_q, rd2_q;
  logic        force1;
  always @(posedge clk) begin
    rd1_q <= rf[rf_raddr1];
    rd2_q <= rf[rf_raddr2];
    if (wb_we && wb_addr != 5'd0) rf[wb_addr] <= wb_data;
  end
  assign rf_rdata1 = force1 ? 32'hDEADBEEF : rd1_q;
  assign rf_rdata2 = rd2_q;

  int n_cmp = 0;
  int n_err = 0;

  function automatic void chk(input string nm, input logic [31:0] act,
                              input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endfunction

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] imm;
    logic [4:0]  dest;
  } exp_t;

  exp_t exp_q[$];

  function automatic void push(input logic [5:0] op, input logic [5:0] fn,
                               input logic [4:0] sh, input logic [31:0] rs,
                               input logic [31:0] rt, input logic [31:0] imm,
                               input logic [4:0] dest);
    exp_t e;
    e.op = op; e.funct = fn; e.shamt = sh;
    e.rs = rs; e.rt = rt; e.imm = imm; e.dest = dest;
    exp_q.push_back(e);
  endfunction

  // Monitor: compares every accepted bundle against the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_bundle", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("opcode", {26'h0, out_opcode}, {26'h0, e.op});
        chk("funct",  {26'h0, out_funct},  {26'h0, e.funct});
        chk("shamt",  {27'h0, out_shamt},  {27'h0, e.shamt});
        chk("rs_val", out_rs_val, e.rs);
        chk("rt_val", out_rt_val, e.rt);
        chk("imm",    out_imm,    e.imm);
        chk("dest",   {27'h0, out_dest},   {27'h0, e.dest});
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [31:0] instr);
    int k;
    for (k = 0; k < 40 && !in_ready; k++) @(posedge clk) #1;
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    in_valid = 1'b1;
    in_instr = instr;
    @(posedge clk) #1;
    in_valid = 1'b0;
  endtask

  // Counts edges from the accept edge (edge 1) to the first cycle with
  // out_valid high, then steps past the following edge.
  task automatic wait_valid(output int edges);
    edges = 1;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) break;
      @(posedge clk);
      edges++;
    end
    if (!out_valid) chk("valid_timeout", 32'd0, 32'd1);
    @(posedge clk) #1;
  endtask

  task automatic wb_pulse(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    @(posedge clk) #1;
    wb_we = 1'b0;
  endtask

  task automatic expect_stall(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      chk("stall_out_valid", {31'h0, out_valid}, 32'd0);
      @(posedge clk) #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0;
    wb_we = 1'b0; wb_addr = 5'h0; wb_data = 32'h0;
    out_ready = 1'b1; force1 = 1'b0;

    // Reset state
    @(posedge clk); @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'h0, out_valid}, 32'd0);
    @(posedge clk) #1;
    reset = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", {31'h0, in_ready}, 32'd1);
    chk("idle_out_dest", {27'h0, out_dest}, 32'd0);
    chk("idle_out_rs", out_rs_val, 32'd0);
    chk("idle_out_imm", out_imm, 32'd0);
    @(posedge clk) #1;

    wb_pulse(5'd10, 32'h10);
    wb_pulse(5'd14, 32'h111);

    // add r8,r10,r14: basic path and latency
    push(6'h00, 6'h20, 5'h0, 32'h10, 32'h111, 32'h4020, 5'd8);
    send(32'h014E4020);
    wait_valid(lat);
    chk("latency_add", lat, 32'd3);
    wb_pulse(5'd8, 32'h0);

    // addi r8,r0,-1 then add r9,r8,r8: RAW stall until writeback
    push(6'h08, 6'h3F, 5'h1F, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd8);
    send(32'h2008FFFF);
    wait_valid(lat);
    push(6'h00, 6'h20, 5'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h4820, 5'd9);
    send(32'h01084820);
    expect_stall(6);
    wb_pulse(5'd8, 32'hFFFFFFFF);
    wait_valid(lat);
    wb_pulse(5'd9, 32'h0);

    // Writeback of rs during the CHECK->READ cycle must be forwarded
    push(6'h00, 6'h20, 5'h0, 32'hAAAA0001, 32'h111, 32'h4020, 5'd8);
    send(32'h014E4020);
    wb_pulse(5'd10, 32'hAAAA0001);
    wait_valid(lat);
    wb_pulse(5'd8, 32'h0);

    // Writeback of rt during the READ cycle must be forwarded
    push(6'h00, 6'h20, 5'h0, 32'hAAAA0001, 32'hBBBB0002, 32'h4020, 5'd8);
    send(32'h014E4020);
    @(posedge clk) #1;
    wb_pulse(5'd14, 32'hBBBB0002);
    wait_valid(lat);
    wb_pulse(5'd8, 32'h0);

    // ori / addi with r0 source: zero vs sign extend, r0 ignores RF and bypass
    force1 = 1'b1;
    push(6'h0D, 6'h00, 5'h0, 32'h0, 32'h0, 32'h00008000, 5'd3);
    send(32'h34038000);
    wb_pulse(5'd0, 32'h12345678);
    wait_valid(lat);
    wb_pulse(5'd3, 32'h0);
    push(6'h08, 6'h00, 5'h0, 32'h0, 32'h0, 32'hFFFF8000, 5'd3);
    send(32'h20038000);
    wait_valid(lat);
    wb_pulse(5'd3, 32'h0);
    force1 = 1'b0;

    // lw r5,4(r10) held in HOLD with out_ready low for 5 cycles
    out_ready = 1'b0;
    push(6'h23, 6'h04, 5'h0, 32'hAAAA0001, 32'h0, 32'h4, 5'd5);
    send(32'h8D450004);
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("hold_valid", {31'h0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'h0, in_ready}, 32'd0);
      chk("hold_rs", out_rs_val, 32'hAAAA0001);
      chk("hold_imm", out_imm, 32'h4);
      chk("hold_dest", {27'h0, out_dest}, 32'd5);
      @(negedge clk);
    end
    // Accept with a same-cycle writeback to r5: the set must win
    @(posedge clk) #1;
    out_ready = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h777;
    @(posedge clk) #1;
    wb_we = 1'b0;
    @(negedge clk);
    chk("post_hold_in_ready", {31'h0, in_ready}, 32'd1);
    chk("post_hold_valid", {31'h0, out_valid}, 32'd0);
    @(posedge clk) #1;

    // add r6,r5,r0 must stall on busy r5
    push(6'h00, 6'h20, 5'h0, 32'h5555, 32'h0, 32'h3020, 5'd6);
    send(32'h00A03020);
    expect_stall(5);
    wb_pulse(5'd5, 32'h5555);
    wait_valid(lat);
    wb_pulse(5'd6, 32'h0);

    // Reset during CHECK with busy r8 aborts and clears the scoreboard
    push(6'h08, 6'h3F, 5'h1F, 32'h0, 32'h0, 32'hFFFFFFFF, 5'd8);
    send(32'h2008FFFF);
    wait_valid(lat);
    send(32'h01084820);
    expect_stall(3);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_in_ready", {31'h0, in_ready}, 32'd0);
    @(posedge clk) #1;
    reset = 1'b0;
    @(negedge clk);
    chk("abort_in_ready_idle", {31'h0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'h0, out_valid}, 32'd0);
    chk("abort_out_dest", {27'h0, out_dest}, 32'd0);
    chk("abort_out_rs", out_rs_val, 32'd0);
    @(posedge clk) #1;
    push(6'h00, 6'h20, 5'h0, 32'h0, 32'h0, 32'h4820, 5'd9);
    send(32'h01084820);
    wait_valid(lat);
    chk("latency_after_reset", lat, 32'd3);
    wb_pulse(5'd9, 32'h0);

    repeat (3) @(posedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
